// File: rtl/icb_axis_regbank_pkg.sv
// icb_axis_regbank_pkg: register offsets, decode kinds and byte-mask helper for icb_axis_regbank
package icb_axis_regbank_pkg;

  localparam logic [11:0] STEP_BASE = 12'h000;
  localparam logic [11:0] POS_BASE  = 12'h100;
  localparam logic [11:0] CTRL      = 12'h200;
  localparam logic [11:0] GO        = 12'h204;
  localparam logic [11:0] EVT       = 12'h208;
  localparam logic [11:0] EVT_EN    = 12'h20C;
  localparam logic [11:0] ID        = 12'h210;

  localparam logic [15:0] DEF_ID_VALUE = 16'hA502;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STEP,
    REG_POS,
    REG_CTRL,
    REG_GO,
    REG_EVT,
    REG_EVT_EN,
    REG_ID
  } reg_sel_e;

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/icb_rsp_slot.sv
// icb_rsp_slot: single-entry ICB response register; one outstanding transaction at a time
module icb_rsp_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic        rsp_ready,
  input  logic [31:0] rdata_d,
  input  logic        err_d,
  output logic        cmd_ready,
  output logic        accept,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  assign cmd_ready = ~rsp_valid | rsp_ready;
  assign accept    = cmd_valid & cmd_ready;

  // A new acceptance overrides the retiring response so back-to-back stays valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end

endmodule

// File: rtl/icb_axis_regbank.sv
// icb_axis_regbank: ICB slave with per-axis step counts, live positions, control, GO pulses and
// W1C event latches feeding a maskable registered interrupt.
module icb_axis_regbank
  import icb_axis_regbank_pkg::*;
#(
  parameter int          NUM_AXIS = 12,
  parameter logic [15:0] ID_VALUE = DEF_ID_VALUE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_icb_cmd_valid,
  output logic                  i_icb_cmd_ready,
  input  logic [31:0]           i_icb_cmd_addr,
  input  logic                  i_icb_cmd_read,
  input  logic [31:0]           i_icb_cmd_wdata,
  input  logic [3:0]            i_icb_cmd_wmask,
  output logic                  i_icb_rsp_valid,
  input  logic                  i_icb_rsp_ready,
  output logic [31:0]           i_icb_rsp_rdata,
  output logic                  i_icb_rsp_err,
  output logic [32*NUM_AXIS-1:0] step_cnt,
  input  logic [32*NUM_AXIS-1:0] position,
  output logic [31:0]           ctrl,
  output logic [NUM_AXIS-1:0]   go,
  input  logic [NUM_AXIS-1:0]   evt,
  output logic                  irq
);

  logic                accept;
  logic                wr;
  logic [11:0]         off;
  logic [5:0]          idx;
  logic                in_rng;
  reg_sel_e            sel;
  logic [31:0]         wm;
  logic [31:0]         wbits;
  logic [31:0]         step_rd;
  logic [31:0]         pos_rd;
  logic [31:0]         rd_data;
  logic [31:0]         step_r [NUM_AXIS];
  logic [NUM_AXIS-1:0] evt_r;
  logic [NUM_AXIS-1:0] evt_en_r;
  logic                unused_addr;

  assign unused_addr = ^{i_icb_cmd_addr[31:12], i_icb_cmd_addr[1:0]};

  assign off    = {i_icb_cmd_addr[11:2], 2'b00};
  assign idx    = i_icb_cmd_addr[7:2];
  assign in_rng = {1'b0, idx} < 7'(NUM_AXIS);

  assign sel = (off[11:8] == STEP_BASE[11:8] && in_rng) ? REG_STEP   :
               (off[11:8] == POS_BASE[11:8]  && in_rng) ? REG_POS    :
               (off == CTRL)                            ? REG_CTRL   :
               (off == GO)                              ? REG_GO     :
               (off == EVT)                             ? REG_EVT    :
               (off == EVT_EN)                          ? REG_EVT_EN :
               (off == ID)                              ? REG_ID     : REG_NONE;

  assign wr    = accept & ~i_icb_cmd_read;
  assign wm    = expand_mask(i_icb_cmd_wmask);
  assign wbits = i_icb_cmd_wdata & wm;

  for (genvar g = 0; g < NUM_AXIS; g++) begin : g_axis
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
        step_r[g] <= '0;
      else if (wr && sel == REG_STEP && idx == 6'(g))
        step_r[g] <= (step_r[g] & ~wm) | wbits;
    assign step_cnt[32*g +: 32] = step_r[g];
  end

  always_comb begin
    step_rd = '0;
    pos_rd  = '0;
    for (int j = 0; j < NUM_AXIS; j++)
      if (idx == 6'(j)) begin
        step_rd = step_r[j];
        pos_rd  = position[32*j +: 32];
      end
  end

  assign rd_data = (sel == REG_STEP)   ? step_rd          :
                   (sel == REG_POS)    ? pos_rd           :
                   (sel == REG_CTRL)   ? ctrl             :
                   (sel == REG_EVT)    ? 32'(evt_r)       :
                   (sel == REG_EVT_EN) ? 32'(evt_en_r)    :
                   (sel == REG_ID)     ? {ID_VALUE, 16'(NUM_AXIS)} : '0;

  // A same-cycle event pulse re-sets the bit after any W1C clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl     <= '0;
      evt_en_r <= '0;
      evt_r    <= '0;
      go       <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && sel == REG_CTRL)
        ctrl <= (ctrl & ~wm) | wbits;
      if (wr && sel == REG_EVT_EN)
        evt_en_r <= (evt_en_r & ~wm[NUM_AXIS-1:0]) | wbits[NUM_AXIS-1:0];
      evt_r <= (evt_r & ~((wr && sel == REG_EVT) ? wbits[NUM_AXIS-1:0] : '0)) | evt;
      go    <= (wr && sel == REG_GO) ? wbits[NUM_AXIS-1:0] : '0;
      irq   <= |(evt_r & evt_en_r);
    end

  icb_rsp_slot u_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (i_icb_cmd_valid),
    .rsp_ready (i_icb_rsp_ready),
    .rdata_d   (i_icb_cmd_read ? rd_data : 32'h0),
    .err_d     (sel == REG_NONE),
    .cmd_ready (i_icb_cmd_ready),
    .accept    (accept),
    .rsp_valid (i_icb_rsp_valid),
    .rsp_rdata (i_icb_rsp_rdata),
    .rsp_err   (i_icb_rsp_err)
  );

endmodule
